// File: rtl/led_decoder_seq.sv
`default_nettype none
// ============================================================================
//  Module   : led_decoder_seq
//  Purpose  : Registered one-hot LED decoder with a 74x138-style three-line
//             enable and built-in auto-scan sequencing (up, down, ping-pong)
//             driven by a programmable prescaler.
//  Ports    :
//    clk     in   1        sole clock, all state on rising edge
//    rst     in   1        synchronous active-high reset
//    enable  in   3        {G1, G2A_n, G2B_n}; decoder active only at 3'b100
//    switch  in   SEL_W    direct select / scan start index
//    mode    in   2        00 DIRECT, 01 SCAN_UP, 10 SCAN_DOWN, 11 PINGPONG
//    period  in   PRESC_W  scan step interval minus one, sampled live
//    led     out  N        registered one-hot LED drive (polarity ACTIVE_LOW)
//    pos     out  SEL_W    registered current index
//    wrap    out  1        one-cycle strobe on the terminal scan step
//  Revision : 1.0  initial release
// ============================================================================
module led_decoder_seq #(
  parameter int SEL_W      = 3,
  parameter int PRESC_W    = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            enable,
  input  logic [SEL_W-1:0]      switch,
  input  logic [1:0]            mode,
  input  logic [PRESC_W-1:0]    period,
  output logic [(1<<SEL_W)-1:0] led,
  output logic [SEL_W-1:0]      pos,
  output logic                  wrap
);

  localparam int N = 1 << SEL_W;

  localparam logic [2:0] EN_ACTIVE      = 3'b100;
  localparam logic [1:0] MODE_DIRECT    = 2'b00;
  localparam logic [1:0] MODE_SCAN_UP   = 2'b01;
  localparam logic [1:0] MODE_SCAN_DOWN = 2'b10;
  localparam logic [1:0] MODE_PINGPONG  = 2'b11;

  localparam logic [N-1:0]     LED_OFF = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};
  localparam logic [N-1:0]     ONE_N   = {{(N-1){1'b0}}, 1'b1};
  localparam logic [SEL_W-1:0] IDX_MAX = {SEL_W{1'b1}};
  localparam logic [SEL_W-1:0] IDX_MIN = {SEL_W{1'b0}};

  // State
  logic [SEL_W-1:0]   idx_q,    idx_d;
  logic [PRESC_W-1:0] presc_q,  presc_d;
  logic               dir_q,    dir_d;     // 1 = counting up
  logic [1:0]         mode_q,   mode_d;
  logic [N-1:0]       led_q,    led_d;
  logic               wrap_q,   wrap_d;

  logic               en;
  logic               pp_step_up;
  logic [N-1:0]       onehot;

  assign en = (enable == EN_ACTIVE);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= IDX_MIN;
      presc_q <= {PRESC_W{1'b0}};
      dir_q   <= 1'b1;
      mode_q  <= MODE_DIRECT;
      led_q   <= LED_OFF;
      wrap_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      presc_q <= presc_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      led_q   <= led_d;
      wrap_q  <= wrap_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    idx_d      = idx_q;
    presc_d    = presc_q;
    dir_d      = dir_q;
    mode_d     = mode_q;
    wrap_d     = 1'b0;
    pp_step_up = 1'b1;

    if (en) begin
      if (mode != mode_q) begin
        // A mode change reloads the start index and restarts the prescaler,
        // so the first step of the new mode is a full interval away.
        mode_d  = mode;
        idx_d   = switch;
        presc_d = {PRESC_W{1'b0}};
        dir_d   = (mode != MODE_SCAN_DOWN);
      end else if (mode_q == MODE_DIRECT) begin
        idx_d   = switch;
        presc_d = {PRESC_W{1'b0}};
      end else if (presc_q != period) begin
        // No clamp when period shrinks below presc: the counter runs on and
        // wraps naturally before matching again.
        presc_d = presc_q + 1'b1;
      end else begin
        presc_d = {PRESC_W{1'b0}};
        case (mode_q)
          MODE_SCAN_UP: begin
            idx_d  = idx_q + 1'b1;
            wrap_d = (idx_q == IDX_MAX);
          end
          MODE_SCAN_DOWN: begin
            idx_d  = idx_q - 1'b1;
            wrap_d = (idx_q == IDX_MIN);
          end
          default: begin
            // Ping-pong never wraps the index. A start index already at the
            // top (loaded with dir = up) simply turns around.
            pp_step_up = dir_q ? (idx_q != IDX_MAX) : (idx_q == IDX_MIN);
            idx_d      = pp_step_up ? (idx_q + 1'b1) : (idx_q - 1'b1);
            dir_d      = pp_step_up;
            if (pp_step_up && (idx_d == IDX_MAX)) begin
              dir_d  = 1'b0;
              wrap_d = 1'b1;
            end else if (!pp_step_up && (idx_d == IDX_MIN)) begin
              dir_d  = 1'b1;
              wrap_d = 1'b1;
            end
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output decode: one-hot of the index being loaded this edge
  // --------------------------------------------------------------------------
  always_comb begin
    onehot = ONE_N << idx_d;
    led_d  = LED_OFF;
    if (en) begin
      led_d = (ACTIVE_LOW != 0) ? ~onehot : onehot;
    end
  end

  // idx only changes on enabled edges, where pos must follow it, so the
  // index register doubles as the registered pos output.
  assign led  = led_q;
  assign pos  = idx_q;
  assign wrap = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_led_decoder_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_decoder_seq
//  Purpose  : Scoreboard bench for led_decoder_seq (SEL_W=3, PRESC_W=4,
//             ACTIVE_LOW=1). Directed vectors push hand-computed expected
//             led/pos/wrap into a queue; a monitor pops one entry per clock
//             edge and compares against the DUT.
//  Revision : 1.0  initial release
// ============================================================================
module tb_led_decoder_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] enable;
  logic [2:0] switch;
  logic [1:0] mode;
  logic [3:0] period;
  logic [7:0] led;
  logic [2:0] pos;
  logic       wrap;

  led_decoder_seq #(
    .SEL_W      (3),
    .PRESC_W    (4),
    .ACTIVE_LOW (1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .switch (switch),
    .mode   (mode),
    .period (period),
    .led    (led),
    .pos    (pos),
    .wrap   (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] led;
    logic [2:0] pos;
    logic       wrap;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  // lit=0 means the bank is expected dark (8'hFF).
  task automatic cyc(input logic r, input logic [2:0] e, input logic [1:0] m,
                     input logic [2:0] sw, input logic [3:0] per,
                     input logic [2:0] p, input bit lit, input bit w);
    exp_t       ex;
    logic [7:0] one;
    rst    = r;
    enable = e;
    mode   = m;
    switch = sw;
    period = per;
    one     = 8'h01;
    ex.id   = vec_id;
    ex.led  = lit ? ~(one << p) : 8'hFF;
    ex.pos  = p;
    ex.wrap = w;
    exp_q.push_back(ex);
    vec_id++;
    @(posedge clk);
    #2;
  endtask

  // Monitor: outputs are registered, so every edge presents a new sample.
  initial begin
    exp_t ex;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        ex = exp_q.pop_front();
        checks++;
        if (led !== ex.led) begin
          errors++;
          $display("FAIL led vec %0d: got %h expected %h", ex.id, led, ex.led);
        end
        checks++;
        if (pos !== ex.pos) begin
          errors++;
          $display("FAIL pos vec %0d: got %0d expected %0d", ex.id, pos, ex.pos);
        end
        checks++;
        if (wrap !== ex.wrap) begin
          errors++;
          $display("FAIL wrap vec %0d: got %b expected %b", ex.id, wrap, ex.wrap);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    //  rst en      mode   sw per   pos lit wrap
    // Reset state
    cyc(1, 3'b100, 2'b00, 0, 0,   0, 0, 0);
    cyc(1, 3'b100, 2'b00, 5, 0,   0, 0, 0);
    // DIRECT decode and enable gating
    cyc(0, 3'b100, 2'b00, 5, 0,   5, 1, 0);   // led = 8'hDF
    cyc(0, 3'b100, 2'b00, 0, 0,   0, 1, 0);   // 8'hFE
    cyc(0, 3'b100, 2'b00, 7, 0,   7, 1, 0);   // 8'h7F
    cyc(0, 3'b000, 2'b00, 3, 0,   7, 0, 0);   // G1 low: dark, idx held
    cyc(0, 3'b101, 2'b00, 3, 0,   7, 0, 0);   // G2B_n high
    cyc(0, 3'b110, 2'b00, 3, 0,   7, 0, 0);   // G2A_n high
    cyc(0, 3'b100, 2'b00, 2, 0,   2, 1, 0);
    // SCAN_UP, period 0, start 6
    cyc(0, 3'b100, 2'b01, 6, 0,   6, 1, 0);
    cyc(0, 3'b100, 2'b01, 6, 0,   7, 1, 0);
    cyc(0, 3'b100, 2'b01, 6, 0,   0, 1, 1);
    cyc(0, 3'b100, 2'b01, 6, 0,   1, 1, 0);
    // SCAN_DOWN, period 2, start 1
    cyc(0, 3'b100, 2'b10, 1, 2,   1, 1, 0);
    cyc(0, 3'b100, 2'b10, 1, 2,   1, 1, 0);
    cyc(0, 3'b100, 2'b10, 1, 2,   1, 1, 0);
    cyc(0, 3'b100, 2'b10, 1, 2,   0, 1, 0);
    cyc(0, 3'b100, 2'b10, 1, 2,   0, 1, 0);
    cyc(0, 3'b100, 2'b10, 1, 2,   0, 1, 0);
    cyc(0, 3'b100, 2'b10, 1, 2,   7, 1, 1);
    cyc(0, 3'b100, 2'b10, 1, 2,   7, 1, 0);
    // PINGPONG, period 0, start 6
    cyc(0, 3'b100, 2'b11, 6, 0,   6, 1, 0);
    cyc(0, 3'b100, 2'b11, 6, 0,   7, 1, 1);
    cyc(0, 3'b100, 2'b11, 6, 0,   6, 1, 0);
    cyc(0, 3'b100, 2'b11, 6, 0,   5, 1, 0);
    cyc(0, 3'b100, 2'b11, 6, 0,   4, 1, 0);
    cyc(0, 3'b100, 2'b11, 6, 0,   3, 1, 0);
    cyc(0, 3'b100, 2'b11, 6, 0,   2, 1, 0);
    cyc(0, 3'b100, 2'b11, 6, 0,   1, 1, 0);
    cyc(0, 3'b100, 2'b11, 6, 0,   0, 1, 1);
    cyc(0, 3'b100, 2'b11, 6, 0,   1, 1, 0);
    cyc(0, 3'b100, 2'b11, 6, 0,   2, 1, 0);
    // Enable gating mid-scan: SCAN_UP period 3, drop enable at presc=2
    cyc(0, 3'b100, 2'b01, 0, 3,   0, 1, 0);   // load, presc 0
    cyc(0, 3'b100, 2'b01, 0, 3,   0, 1, 0);   // presc 1
    cyc(0, 3'b100, 2'b01, 0, 3,   0, 1, 0);   // presc 2
    for (int i = 0; i < 5; i++) begin
      cyc(0, 3'b000, 2'b01, 0, 3, 0, 0, 0);   // dark, everything held
    end
    cyc(0, 3'b100, 2'b01, 0, 3,   0, 1, 0);   // presc 3
    cyc(0, 3'b100, 2'b01, 0, 3,   1, 1, 0);   // step on 2nd enabled edge
    cyc(0, 3'b100, 2'b01, 0, 3,   1, 1, 0);
    cyc(0, 3'b100, 2'b01, 0, 3,   1, 1, 0);
    cyc(0, 3'b100, 2'b01, 0, 3,   1, 1, 0);
    cyc(0, 3'b100, 2'b01, 0, 3,   2, 1, 0);
    // Sync reset mid-PINGPONG while heading down at pos 4
    cyc(0, 3'b100, 2'b11, 6, 0,   6, 1, 0);
    cyc(0, 3'b100, 2'b11, 6, 0,   7, 1, 1);
    cyc(0, 3'b100, 2'b11, 6, 0,   6, 1, 0);
    cyc(0, 3'b100, 2'b11, 6, 0,   5, 1, 0);
    cyc(0, 3'b100, 2'b11, 6, 0,   4, 1, 0);
    cyc(1, 3'b100, 2'b11, 2, 0,   0, 0, 0);
    cyc(0, 3'b100, 2'b11, 2, 0,   2, 1, 0);   // mode change loads switch
    cyc(0, 3'b100, 2'b11, 2, 0,   3, 1, 0);   // restarts upward
    cyc(0, 3'b100, 2'b11, 2, 0,   4, 1, 0);

    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_decoder_seq.md
# led_decoder_seq

Parametrised, registered one-hot LED decoder with 74x138-style three-line enable and built-in scan sequencing. Sits between switch/control inputs and the board LED bank. Generalises the fixed 3-to-8 active-low decoder: select width, output polarity and step rate are parameters. Adds up, down and ping-pong auto-scan modes with a programmable prescaler and a wrap strobe.

## Interface
Parameters:
- SEL_W, 3, select width; LED count N = 2^SEL_W.
- PRESC_W, 4, width of `period` and the internal prescaler.
- ACTIVE_LOW, 1, 1: lit LED = 0, dark = 1; 0: inverted.

Ports:
- clk  in  1  sole clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  3  {G1, G2A_n, G2B_n}; decoder enabled only when enable == 3'b100.
- switch  in  SEL_W  direct select / scan start index.
- mode  in  2  00 DIRECT, 01 SCAN_UP, 10 SCAN_DOWN, 11 PINGPONG.
- period  in  PRESC_W  scan step interval minus one, sampled live.
- led  out  N  registered one-hot LED drive, polarity per ACTIVE_LOW.
- pos  out  SEL_W  registered current index.
- wrap  out  1  one-cycle strobe on terminal step.

## Operation
- State: idx (SEL_W), presc (PRESC_W), dir (1 = up), mode_q (2), led, wrap.
- Enabled (en) = (enable == 3'b100). OFF = all N bits dark (all 1s if ACTIVE_LOW, else all 0s).
- Reset (rst=1): led = OFF, idx = 0, pos = 0, presc = 0, dir = up, mode_q = 00, wrap = 0. Reset overrides every other input, mid-scan included.
- !en: led <= OFF; idx, presc, dir, mode_q hold; wrap <= 0.
- en, mode != mode_q (mode change): mode_q <= mode; idx <= switch; presc <= 0; dir <= 0 if mode == SCAN_DOWN, else up; wrap <= 0.
- en, DIRECT: idx <= switch; presc <= 0; wrap <= 0.
- en, scan modes, presc != period: presc <= presc + 1; idx holds; wrap <= 0.
- en, scan modes, presc == period: presc <= 0; idx steps.
  - SCAN_UP: idx + 1 mod N; wrap <= 1 on N-1 -> 0.
  - SCAN_DOWN: idx - 1 mod N; wrap <= 1 on 0 -> N-1.
  - PINGPONG: step in dir.
    - Landing on N-1 going up: dir <= down, wrap <= 1.
    - Landing on 0 going down: dir <= up, wrap <= 1.
    - idx never wraps in PINGPONG.
- In every en cycle, led <= onehot(new idx), polarity applied; pos <= new idx. Invariant while enabled: exactly one LED lit, at bit pos.
- period shrinking below current presc: next step occurs when presc wraps naturally at 2^PRESC_W - 1 -> 0. Required behaviour; no early clamp.

## Timing
- DIRECT latency: switch at edge k appears on led/pos after edge k (1 cycle), identical to the legacy decoder.
- Scan step interval: period + 1 enabled cycles. period = 0 steps every enabled cycle.
- Disabled cycles do not advance presc: scan timing counts enabled cycles only.
- wrap is registered, high exactly one cycle, coincident with the led/pos update it marks.
- Mode change takes effect on the first enabled edge after the change. That edge loads switch; the first scan step follows period + 1 enabled cycles later.
- Re-enable after !en: led shows held idx on the first enabled edge, with no step unless presc == period.

## Test plan
- Reset/DIRECT (SEL_W=3, ACTIVE_LOW=1): rst=1 -> led=8'hFF, pos=0. Then enable=3'b100, mode=00, switch=5 -> led=8'hDF one cycle later. enable=3'b000 -> led=8'hFF.
- SCAN_UP, period=0, from switch=6: pos sequence 6,7,0,1 on successive edges; wrap=1 only on the cycle pos becomes 0.
- SCAN_DOWN, period=2, switch=1: pos 1 for 3 cycles, then 0, then 7 with wrap=1.
- PINGPONG, period=0, switch=6: pos 6,7,6,5,…,0,1; wrap=1 on landing at 7 and at 0; never 7->0.
- Enable gating mid-scan: SCAN_UP period=3. Drop enable for 5 cycles at presc=2: led=8'hFF, pos held. On re-enable, the step occurs after exactly 2 more enabled cycles.
- Sync reset mid-PINGPONG while dir=down at pos=4: next edge led=8'hFF, pos=0, wrap=0. After reset with mode=11 and en: idx loads switch, scan restarts upward.
